// File: rtl/ap_job_ctrl_if.sv
// Host and AP-tile signal bundle for the AP job sequencer.
// master: the surrounding system (host bridge plus AP tile); slave: ap_job_ctrl.
interface ap_job_ctrl_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_W    = 9
);
  // Host job channel
  logic                 job_valid;
  logic                 job_ready;
  logic [2:0]           job_cmd;
  logic [ADDR_W:0]      job_len;
  // Operand stream
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_data;
  // Result stream
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_data;
  // Status
  logic                 busy;
  logic                 done;
  logic                 err;
  // AP tile pins
  logic                 ap_rst;
  logic                 ap_mode;
  logic [2:0]           ap_cmd;
  logic [1:0]           ap_sel_col;
  logic [ADDR_W-1:0]    ap_addr;
  logic [WORD_SIZE-1:0] ap_data_in;
  logic                 ap_write_en;
  logic                 ap_read_en;
  logic [WORD_SIZE-1:0] ap_data_out;
  logic                 ap_irq;

  modport master (
    output job_valid, job_cmd, job_len, in_valid, in_data, out_ready,
           ap_data_out, ap_irq,
    input  job_ready, in_ready, out_valid, out_data, busy, done, err,
           ap_rst, ap_mode, ap_cmd, ap_sel_col, ap_addr, ap_data_in,
           ap_write_en, ap_read_en
  );

  modport slave (
    input  job_valid, job_cmd, job_len, in_valid, in_data, out_ready,
           ap_data_out, ap_irq,
    output job_ready, in_ready, out_valid, out_data, busy, done, err,
           ap_rst, ap_mode, ap_cmd, ap_sel_col, ap_addr, ap_data_in,
           ap_write_en, ap_read_en
  );
endinterface

// File: rtl/ap_job_ctrl.sv
// Job sequencer for one associative-processor tile: validates a job, loads
// columns A/B through the AP write port, runs the bit-serial operation and
// streams column C back to the host one word at a time.
module ap_job_ctrl #(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512,
  parameter int ADDR_W     = 9,
  parameter int RD_LAT     = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic         clka,
  input  logic         rst,
  ap_job_ctrl_if.slave bus
);

  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam int LAT_W = $clog2(RD_LAT) + 1;

  localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W+1)'(CELL_QUANT);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
  localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);

  typedef enum logic [3:0] {
    IDLE, CHECK, CLR, WR_A0, WR_A1, WR_B0, WR_B1,
    COMPUTE, RD_ISSUE, RD_WAIT, OUT, FIN
  } state_t;

  typedef enum logic [1:0] {
    COL_A = 2'd0,
    COL_B = 2'd1,
    COL_C = 2'd2
  } col_t;

  state_t state, state_nxt;

  // Job registers and datapath state
  logic [2:0]           cmd_q;
  logic [2:0]           ap_cmd_q;
  logic [ADDR_W:0]      len_q;
  logic [ADDR_W-1:0]    cnt;
  logic [TMR_W-1:0]     tmr;
  logic [LAT_W-1:0]     lat_cnt;
  logic                 err_q;
  logic                 irq_q;
  logic [WORD_SIZE-1:0] rd_data;
  logic [WORD_SIZE-1:0] wr_data;

  // Decoded per-state controls
  logic job_ready, in_ready, out_valid, done;
  logic ap_rst, ap_mode, ap_write_en, ap_read_en, addr_on;
  col_t sel;

  logic last_word, irq_rise, bad_job;

  // cnt is one bit narrower than len, so the last word is detected by
  // compare rather than by letting cnt reach len (which would wrap at 512).
  assign last_word = ({1'b0, cnt} == (len_q - LEN_ONE));
  // Only a 0->1 transition counts; a level left over from the previous job
  // must not end this one early.
  assign irq_rise  = bus.ap_irq & ~irq_q;
  assign bad_job   = (cmd_q > 3'd3) || (len_q == '0) || (len_q > MAX_LEN);

  // State register
  always_ff @(posedge clka) begin
    // NOTE: clocked state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state control decode
  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // the block leaves one unassigned, which would infer a latch.
    state_nxt   = state;
    job_ready   = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    ap_rst      = 1'b0;
    ap_mode     = 1'b0;
    ap_write_en = 1'b0;
    ap_read_en  = 1'b0;
    addr_on     = 1'b0;
    sel         = COL_A;

    unique case (state)
      IDLE: begin
        job_ready = 1'b1;
        if (bus.job_valid) state_nxt = CHECK;
      end
      CHECK: state_nxt = bad_job ? FIN : CLR;
      CLR: begin
        ap_rst    = 1'b1;
        state_nxt = WR_A0;
      end
      WR_A0, WR_B0: begin
        in_ready = 1'b1;
        addr_on  = 1'b1;
        sel      = (state == WR_B0) ? COL_B : COL_A;
        if (bus.in_valid) begin
          ap_write_en = 1'b1;
          state_nxt   = (state == WR_B0) ? WR_B1 : WR_A1;
        end
      end
      WR_A1: begin
        addr_on = 1'b1;
        sel     = COL_A;
        if (!last_word)           state_nxt = WR_A0;
        else if (cmd_q == 3'd3)   state_nxt = COMPUTE;
        else                      state_nxt = WR_B0;
      end
      WR_B1: begin
        addr_on   = 1'b1;
        sel       = COL_B;
        state_nxt = last_word ? COMPUTE : WR_B0;
      end
      COMPUTE: begin
        ap_mode = 1'b1;
        if (irq_rise)              state_nxt = RD_ISSUE;
        else if (tmr == TMR_LAST)  state_nxt = FIN;
      end
      RD_ISSUE: begin
        ap_read_en = 1'b1;
        addr_on    = 1'b1;
        sel        = COL_C;
        state_nxt  = RD_WAIT;
      end
      RD_WAIT: begin
        addr_on = 1'b1;
        sel     = COL_C;
        if (lat_cnt == LAT_LAST) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        addr_on   = 1'b1;
        sel       = COL_C;
        if (bus.out_ready) state_nxt = last_word ? FIN : RD_ISSUE;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job latch, address/timer/latency counters, error flag and data capture
  always_ff @(posedge clka) begin
    if (rst) begin
      cmd_q    <= '0;
      ap_cmd_q <= '0;
      len_q    <= '0;
      cnt      <= '0;
      tmr      <= '0;
      lat_cnt  <= '0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      rd_data  <= '0;
      wr_data  <= '0;
    end else begin
      irq_q   <= bus.ap_irq;
      tmr     <= (state == COMPUTE) ? tmr + TMR_ONE : '0;
      lat_cnt <= (state == RD_WAIT) ? lat_cnt + LAT_ONE : '0;
      unique case (state)
        IDLE: begin
          if (bus.job_valid) begin
            cmd_q <= bus.job_cmd;
            len_q <= bus.job_len;
          end
        end
        CHECK: if (bad_job) err_q <= 1'b1;
        CLR: begin
          cnt      <= '0;
          ap_cmd_q <= cmd_q;
        end
        WR_A0, WR_B0: if (bus.in_valid) wr_data <= bus.in_data;
        WR_A1, WR_B1: cnt <= last_word ? '0 : cnt + CNT_ONE;
        COMPUTE: begin
          cnt <= '0;
          if (!irq_rise && (tmr == TMR_LAST)) err_q <= 1'b1;
        end
        RD_WAIT: if (lat_cnt == LAT_LAST) rd_data <= bus.ap_data_out;
        OUT: if (bus.out_ready && !last_word) cnt <= cnt + CNT_ONE;
        FIN: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.job_ready   = job_ready;
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = rd_data;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done;
  assign bus.err         = err_q;
  assign bus.ap_rst      = ap_rst;
  assign bus.ap_mode     = ap_mode;
  assign bus.ap_cmd      = ap_cmd_q;
  assign bus.ap_sel_col  = sel;
  assign bus.ap_addr     = addr_on ? cnt : '0;
  assign bus.ap_data_in  = ap_write_en ? bus.in_data : wr_data;
  assign bus.ap_write_en = ap_write_en;
  assign bus.ap_read_en  = ap_read_en;

endmodule

// File: tb/tb_ap_job_ctrl.sv
// Directed self-checking bench for ap_job_ctrl with a small AP tile model.
module tb_ap_job_ctrl;

  localparam int TIMEOUT = 64;

  logic clka = 1'b0;
  logic rst  = 1'b1;

  always #5 clka = ~clka;

  ap_job_ctrl_if #(.WORD_SIZE(8), .ADDR_W(9)) bus ();

  ap_job_ctrl #(
    .WORD_SIZE(8), .CELL_QUANT(512), .ADDR_W(9), .RD_LAT(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clka(clka),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- AP tile model ----------------
  logic [7:0] col_a [512];
  logic [7:0] col_b [512];
  logic [7:0] col_c [512];
  logic [7:0] rd_p1;
  int         mode_cnt = 0;
  int         irq_delay = 20;
  logic       irq_hold = 1'b0;

  function automatic logic [7:0] ap_op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      3'd0:    return a | b;
      3'd1:    return a ^ b;
      3'd2:    return a & b;
      default: return ~a;
    endcase
  endfunction

  // Column writes and the two-stage read pipeline
  always @(posedge clka) begin
    if (bus.ap_write_en) begin
      if (bus.ap_sel_col == 2'd0) col_a[bus.ap_addr] <= bus.ap_data_in;
      if (bus.ap_sel_col == 2'd1) col_b[bus.ap_addr] <= bus.ap_data_in;
    end
    rd_p1           <= bus.ap_read_en ? col_c[bus.ap_addr] : 8'h00;
    bus.ap_data_out <= rd_p1;
  end

  // Operation completion: irq rises irq_delay cycles into ap_mode, cleared by ap_rst
  always @(negedge clka) begin
    if (rst) begin
      bus.ap_irq <= 1'b0;
      mode_cnt   <= 0;
    end else if (irq_hold) begin
      bus.ap_irq <= 1'b1;
    end else begin
      if (bus.ap_rst) bus.ap_irq <= 1'b0;
      if (bus.ap_mode) begin
        mode_cnt <= mode_cnt + 1;
        if (mode_cnt + 1 == irq_delay) begin
          for (int i = 0; i < 512; i++) col_c[i] <= ap_op(bus.ap_cmd, col_a[i], col_b[i]);
          bus.ap_irq <= 1'b1;
        end
      end else begin
        mode_cnt <= 0;
      end
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0;
  int n_we = 0, n_we_b = 0, n_we_bad = 0, n_aprst = 0, n_mode = 0;
  int n_rd_bad = 0, n_ov = 0, n_done = 0, done_cyc = 0;
  logic done_err = 1'b0;
  logic [2:0] last_cmd = 3'd0;

  always @(posedge clka) cyc <= cyc + 1;

  always @(negedge clka) begin
    if (bus.ap_write_en) begin
      n_we <= n_we + 1;
      if (bus.ap_sel_col == 2'd1) n_we_b <= n_we_b + 1;
      if (!(bus.in_valid && bus.in_ready)) n_we_bad <= n_we_bad + 1;
    end
    if (bus.ap_rst) n_aprst <= n_aprst + 1;
    if (bus.ap_mode) begin
      n_mode   <= n_mode + 1;
      last_cmd <= bus.ap_cmd;
    end
    if (bus.ap_read_en && bus.ap_sel_col != 2'd2) n_rd_bad <= n_rd_bad + 1;
    if (bus.out_valid) n_ov <= n_ov + 1;
    if (bus.done) begin
      n_done   <= n_done + 1;
      done_err <= bus.err;
      done_cyc <= cyc;
    end
  end

  // ---------------- host driver ----------------
  logic [7:0] qa[$], qb[$], qexp[$], qgot[$];
  int acc_cyc = 0;
  int n_unstable = 0;

  task automatic send_job(input logic [2:0] c, input logic [9:0] l);
    int w = 0;
    bus.job_cmd = c; bus.job_len = l; bus.job_valid = 1'b1;
    while (!bus.job_ready && w < 100) begin @(negedge clka); w++; end
    if (w >= 100) check("job_ready_wait", 32'd0, 32'd1);
    acc_cyc = cyc;
    @(negedge clka);
    bus.job_valid = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] d, input int gap);
    int w = 0;
    bus.in_data = d; bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 200) begin @(negedge clka); w++; end
    if (w >= 200) check("in_ready_wait", 32'd0, 32'd1);
    @(negedge clka);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clka);
  endtask

  task automatic collect(input int n, input int stall);
    logic [7:0] d0;
    qgot = {};
    for (int k = 0; k < n; k++) begin
      int w = 0;
      bus.out_ready = 1'b0;
      while (!bus.out_valid && w < 300) begin @(negedge clka); w++; end
      if (w >= 300) begin check("out_valid_wait", 32'd0, 32'd1); return; end
      d0 = bus.out_data;
      repeat (stall) begin
        @(negedge clka);
        if (!bus.out_valid || bus.out_data !== d0) n_unstable++;
      end
      qgot.push_back(bus.out_data);
      bus.out_ready = 1'b1;
      @(negedge clka);
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic wait_done(input int base);
    int w = 0;
    while (n_done == base && w < 400) begin @(negedge clka); w++; end
    if (w >= 400) check("done_wait", 32'd0, 32'd1);
  endtask

  task automatic feed(input logic [2:0] c, input int gap);
    foreach (qa[i]) push_word(qa[i], gap);
    if (c != 3'd3) foreach (qb[i]) push_word(qb[i], gap);
  endtask

  task automatic check_words(input string tag);
    check({tag, "_count"}, qgot.size(), qexp.size());
    foreach (qexp[i])
      check($sformatf("%s_w%0d", tag, i), (i < qgot.size()) ? {24'd0, qgot[i]} : 32'hDEAD, qexp[i]);
  endtask

  // ---------------- stimulus ----------------
  int b_we, b_web, b_wbad, b_rst, b_mode, b_rdbad, b_ov, b_done;

  task automatic snap();
    @(negedge clka);
    b_we = n_we; b_web = n_we_b; b_wbad = n_we_bad; b_rst = n_aprst; b_mode = n_mode;
    b_rdbad = n_rd_bad; b_ov = n_ov; b_done = n_done;
  endtask

  initial begin
    bus.job_valid = 1'b0; bus.job_cmd = '0; bus.job_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    repeat (3) @(negedge clka);
    check("rst_job_ready", bus.job_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ap_mode", bus.ap_mode, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_ap_outs", {bus.ap_rst, bus.ap_write_en, bus.ap_read_en, bus.ap_addr}, 0);
    rst = 1'b0;

    // AND, len 4, irq 20 cycles into COMPUTE
    snap();
    qa = {8'hFF, 8'h0F, 8'hAA, 8'h00}; qb = {8'h0F, 8'hFF, 8'h55, 8'hFF};
    qexp = {8'h0F, 8'h0F, 8'h00, 8'h00};
    irq_delay = 20;
    send_job(3'd2, 10'd4);
    check("and_busy", bus.busy, 1);
    feed(3'd2, 0);
    collect(4, 0);
    wait_done(b_done);
    check_words("and");
    check("and_writes", n_we - b_we, 8);
    check("and_b_writes", n_we_b - b_web, 4);
    check("and_ap_rst", n_aprst - b_rst, 1);
    check("and_mode_cycles", n_mode - b_mode, 20);
    check("and_ap_cmd", last_cmd, 2);
    check("and_col_a2", col_a[2], 8'hAA);
    check("and_col_b1", col_b[1], 8'hFF);
    check("and_done_err", {n_done - b_done, 31'd0} | done_err, 32'h8000_0000);

    // NOT(A), len 2: column A only
    snap();
    qa = {8'h5A, 8'h00}; qb = {}; qexp = {8'hA5, 8'hFF};
    irq_delay = 7;
    send_job(3'd3, 10'd2);
    feed(3'd3, 0);
    collect(2, 0);
    wait_done(b_done);
    check_words("not");
    check("not_writes", n_we - b_we, 2);
    check("not_b_writes", n_we_b - b_web, 0);
    check("not_read_col", n_rd_bad - b_rdbad, 0);
    check("not_done", n_done - b_done, 1);
    check("not_err", done_err, 0);

    // Rejected jobs: illegal cmd, zero length, length above CELL_QUANT
    snap();
    send_job(3'd5, 10'd2);   wait_done(b_done);
    check("rej_cmd_err", done_err, 1);
    check("rej_cmd_lat", done_cyc - acc_cyc, 2);
    send_job(3'd0, 10'd0);   wait_done(b_done + 1);
    check("rej_len0_err", done_err, 1);
    check("rej_len0_lat", done_cyc - acc_cyc, 2);
    send_job(3'd1, 10'd513); wait_done(b_done + 2);
    check("rej_len513_err", done_err, 1);
    check("rej_len513_lat", done_cyc - acc_cyc, 2);
    @(negedge clka);
    check("rej_err_cleared", bus.err, 0);
    check("rej_ap_activity", (n_we - b_we) + (n_mode - b_mode) + (n_aprst - b_rst), 0);

    // Timeout: irq level stuck high, no rising edge
    snap();
    irq_hold = 1'b1;
    qa = {8'h11}; qb = {8'h22};
    send_job(3'd1, 10'd1);
    feed(3'd1, 0);
    wait_done(b_done);
    check("to_mode_cycles", n_mode - b_mode, TIMEOUT);
    check("to_err", done_err, 1);
    check("to_out_valid", n_ov - b_ov, 0);
    check("to_ap_mode", bus.ap_mode, 0);
    irq_hold = 1'b0;

    // OR, len 3, 3-cycle input gaps and 5-cycle output stalls
    snap();
    qa = {8'h12, 8'h34, 8'hF0}; qb = {8'h21, 8'h03, 8'h0F};
    qexp = {8'h33, 8'h37, 8'hFF};
    irq_delay = 9;
    n_unstable = 0;
    send_job(3'd0, 10'd3);
    feed(3'd0, 3);
    collect(3, 5);
    wait_done(b_done);
    check_words("or");
    check("or_writes", n_we - b_we, 6);
    check("or_we_no_hs", n_we_bad - b_wbad, 0);
    check("or_stable", n_unstable, 0);
    check("or_err", done_err, 0);

    // Reset in the middle of COMPUTE, then a fresh XOR job
    snap();
    irq_delay = 1000;
    qa = {8'h3C}; qb = {8'hC3};
    send_job(3'd0, 10'd1);
    feed(3'd0, 0);
    for (int w = 0; w < 20 && !bus.ap_mode; w++) @(negedge clka);
    check("mid_in_compute", bus.ap_mode, 1);
    repeat (3) @(negedge clka);
    rst = 1'b1;
    @(negedge clka);
    check("mid_ap_mode", bus.ap_mode, 0);
    check("mid_busy", bus.busy, 0);
    check("mid_job_ready", bus.job_ready, 1);
    rst = 1'b0;
    repeat (3) @(negedge clka);
    check("mid_no_done", n_done - b_done, 0);

    snap();
    irq_delay = 5;
    qa = {8'hFF, 8'h00, 8'hAA}; qb = {8'h0F, 8'h0F, 8'h0F};
    qexp = {8'hF0, 8'h0F, 8'hA5};
    send_job(3'd1, 10'd3);
    feed(3'd1, 0);
    collect(3, 0);
    wait_done(b_done);
    check_words("xor");
    check("xor_err", done_err, 0);

    repeat (3) @(negedge clka);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
